// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared FSM states, access size codes and byte-lane mask helper
package mem_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LD_RSP, ST_WRITE, ST_COMMIT} state_t;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_BAD  = 2'd3;
    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
        return size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? 4'b0011 << off : 4'b1111;
    endfunction
endpackage

// File: rtl/ls_lane_fmt.sv
// ls_lane_fmt: load lane extract/extend and store lane merge into the old memory word
module ls_lane_fmt
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        uns,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);
    logic [31:0] sh_r;
    logic [31:0] sh_w;
    logic [3:0]  mask;
    assign sh_r = rdata >> {off, 3'b000};
    assign sh_w = wdata << {off, 3'b000};
    assign mask = byte_mask(size, off);
    assign load_data = size == SZ_BYTE ? {{24{~uns & sh_r[7]}}, sh_r[7:0]} :
                       size == SZ_HALF ? {{16{~uns & sh_r[15]}}, sh_r[15:0]} : rdata;
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign store_data[8*i +: 8] = mask[i] ? sh_w[8*i +: 8] : rdata[8*i +: 8];
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences fetch and load/store accesses to a 2R/1W byte memory,
// with sub-word read-modify-write stores, alignment/range checks and store->fetch stall.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_SIZE = 1024,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [31:0]     if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_valid,
    output logic            if_err,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [1:0]      ls_size,
    input  logic            ls_unsigned,
    input  logic [31:0]     ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_done,
    output logic            ls_err,
    output logic [XLEN-1:0] ls_rdata,
    output logic            mem_r_enable,
    output logic [31:0]     mem_r_addr1,
    output logic [31:0]     mem_r_addr2,
    input  logic [XLEN-1:0] mem_rdata1,
    input  logic [XLEN-1:0] mem_rdata2,
    output logic            mem_w_enable,
    output logic [31:0]     mem_w_addr,
    output logic [XLEN-1:0] mem_w_data
);
    state_t state, next;
    logic [32:0] ls_top, if_top;
    logic ls_bad, accept, hazard;
    logic [XLEN-1:0] ld_data, st_data;
    assign ls_top = {1'b0, ls_addr[31:2], 2'b00} + 33'd3;
    assign if_top = {1'b0, if_addr} + 33'd3;
    assign ls_bad = (ls_size == SZ_HALF & ls_addr[0]) | (ls_size == SZ_WORD & |ls_addr[1:0]) |
                    ls_size == SZ_BAD | ls_top >= 33'(MEM_SIZE);
    assign accept = state == IDLE & ls_req;
    assign mem_r_enable = accept;
    assign mem_r_addr1 = if_addr;
    assign mem_r_addr2 = {ls_addr[31:2], 2'b00};
    assign if_rdata = mem_rdata1;
    assign if_err = if_req & (|if_addr[1:0] | if_top >= 33'(MEM_SIZE));
    // the word being stored is stale in memory until the commit negedge has passed
    assign hazard = (state == ST_WRITE | state == ST_COMMIT) & if_addr[31:2] == mem_w_addr[31:2];
    assign if_valid = if_req & ~if_err & ~hazard;
    ls_lane_fmt u_fmt (
        .size      (ls_size),
        .off       (ls_addr[1:0]),
        .uns       (ls_unsigned),
        .rdata     (mem_rdata2),
        .wdata     (ls_wdata),
        .load_data (ld_data),
        .store_data(st_data)
    );
    always_comb begin
        next = state;
        next = state == IDLE ? (!ls_req ? IDLE : (ls_we & ~ls_bad) ? ST_WRITE : LD_RSP) :
               state == ST_WRITE ? ST_COMMIT : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ls_done      <= 1'b0;
            ls_err       <= 1'b0;
            ls_rdata     <= '0;
            mem_w_enable <= 1'b0;
            mem_w_addr   <= '0;
            mem_w_data   <= '0;
        end else begin
            ls_done      <= next == LD_RSP | next == ST_COMMIT;
            ls_err       <= accept & ls_bad;
            mem_w_enable <= next == ST_WRITE;
            if (accept & ~ls_we) ls_rdata <= ls_bad ? '0 : ld_data;
            if (accept & ls_we & ~ls_bad) begin
                mem_w_addr <= {ls_addr[31:2], 2'b00};
                mem_w_data <= st_data;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed + random load/store/fetch traffic against a byte-array reference model
module tb_mem_access_ctrl;
    localparam int MS = 1024;
    logic clk = 1'b0, rst_n = 1'b0;
    logic if_req = 1'b0, if_valid, if_err;
    logic [31:0] if_addr = '0, if_rdata;
    logic ls_req = 1'b0, ls_we = 1'b0, ls_unsigned = 1'b0, ls_done, ls_err;
    logic [1:0] ls_size = 2'd0;
    logic [31:0] ls_addr = '0, ls_wdata = '0, ls_rdata;
    logic mem_r_enable, mem_w_enable;
    logic [31:0] mem_r_addr1, mem_r_addr2, mem_rdata1, mem_rdata2, mem_w_addr, mem_w_data;
    logic [7:0] envm [0:MS-1];
    logic [7:0] refm [0:MS-1];
    logic load_env = 1'b0, wp = 1'b0;
    logic [31:0] wa = '0, wdat = '0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_err(ls_err), .ls_rdata(ls_rdata),
        .mem_r_enable(mem_r_enable), .mem_r_addr1(mem_r_addr1), .mem_r_addr2(mem_r_addr2),
        .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2),
        .mem_w_enable(mem_w_enable), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data)
    );

    // memory: async reads, write registered on posedge and landing on the following negedge
    assign mem_rdata1 = (mem_r_addr1 < 32'(MS-3)) ? {envm[mem_r_addr1[9:0]+10'd3], envm[mem_r_addr1[9:0]+10'd2],
                        envm[mem_r_addr1[9:0]+10'd1], envm[mem_r_addr1[9:0]]} : 32'h0;
    assign mem_rdata2 = (mem_r_addr2 < 32'(MS-3)) ? {envm[mem_r_addr2[9:0]+10'd3], envm[mem_r_addr2[9:0]+10'd2],
                        envm[mem_r_addr2[9:0]+10'd1], envm[mem_r_addr2[9:0]]} : 32'h0;
    always @(posedge clk) begin
        wp   <= mem_w_enable;
        wa   <= mem_w_addr;
        wdat <= mem_w_data;
    end
    always @(negedge clk) begin
        if (load_env) begin
            for (int i = 0; i < MS; i++) envm[i] <= refm[i];
        end else if (wp && wa < 32'(MS-3)) begin
            for (int i = 0; i < 4; i++) envm[wa[9:0]+10'(i)] <= wdat[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'(a / 4) * 4;
        return {refm[b+3], refm[b+2], refm[b+1], refm[b]};
    endfunction

    function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
        longint base;
        base = (longint'(a) / 4) * 4;
        return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || base + 3 >= MS;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(refm[int'(a)+i]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic [7:0] b [4];
        int base;
        base = int'(a / 4) * 4;
        for (int i = 0; i < 4; i++) b[i] = refm[base+i];
        for (int i = 0; i < (1 << sz); i++) b[int'(a % 4)+i] = wd[8*i +: 8];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) refm[int'(a)+i] = wd[8*i +: 8];
    endtask

    task automatic check_fetch(input logic hz, input logic [31:0] ha, input string tag);
        logic e, v;
        e = if_req && (if_addr % 4 != 0 || longint'(if_addr) + 3 >= MS);
        v = if_req && !e && !(hz && (if_addr / 4 == ha / 4));
        chk({tag, "_iferr"}, 32'(if_err), 32'(e));
        chk({tag, "_ifvalid"}, 32'(if_valid), 32'(v));
        if (v) chk({tag, "_ifdata"}, if_rdata, ref_word(if_addr));
    endtask

    task automatic do_ls(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] fa);
        logic e;
        logic [31:0] exp_rd, exp_wd;
        int n;
        e = m_err(sz, a);
        exp_rd = e ? 32'h0 : m_load(sz, uns, a);
        exp_wd = e ? 32'h0 : m_merge(sz, a, wd);
        ls_req = 1'b1; ls_we = we; ls_size = sz; ls_unsigned = uns; ls_addr = a; ls_wdata = wd; if_addr = fa;
        #1;
        chk("r_enable", 32'(mem_r_enable), 32'd1);
        chk("r_addr2", mem_r_addr2, (a / 4) * 4);
        check_fetch(1'b0, a, "idle");
        n = 0;
        do begin
            tick;
            n++;
            check_fetch(we && !e, a, "busy");
            if (we && !e && n == 1) begin
                chk("w_enable_st", 32'(mem_w_enable), 32'd1);
                chk("w_addr", mem_w_addr, (a / 4) * 4);
                chk("w_data", mem_w_data, exp_wd);
            end else chk("w_enable_idle", 32'(mem_w_enable), 32'd0);
        end while (!ls_done && n < 6);
        chk("done", 32'(ls_done), 32'd1);
        chk("latency", n, (we && !e) ? 32'd2 : 32'd1);
        chk("ls_err", 32'(ls_err), 32'(e));
        if (!we && !e) chk("ls_rdata", ls_rdata, exp_rd);
        if (we && !e) m_store(sz, a, wd);
        ls_req = 1'b0;
        tick;
        chk("done_clr", 32'(ls_done), 32'd0);
        chk("r_enable_off", 32'(mem_r_enable), 32'd0);
        check_fetch(1'b0, a, "after");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        logic [1:0] sz;
        logic [31:0] a, fa;
        for (int i = 0; i < MS; i++) refm[i] = 8'($urandom);
        refm[16] = 8'hEF; refm[17] = 8'hBE; refm[18] = 8'hAD; refm[19] = 8'hDE;
        load_env = 1'b1;
        repeat (2) @(negedge clk);
        load_env = 1'b0;
        #1;
        chk("rst_done", 32'(ls_done), 32'd0);
        chk("rst_err", 32'(ls_err), 32'd0);
        chk("rst_wen", 32'(mem_w_enable), 32'd0);
        chk("rst_rdata", ls_rdata, 32'd0);
        chk("rst_waddr", mem_w_addr, 32'd0);
        chk("rst_wdata", mem_w_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        if_req = 1'b1;
        tick;
        // sign/zero-extended byte loads
        do_ls(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h20);
        chk("t1_lb", ls_rdata, 32'hFFFF_FFDE);
        do_ls(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h20);
        chk("t1_lbu", ls_rdata, 32'h0000_00DE);
        // half store merge then word readback
        do_ls(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234, 32'h20);
        chk("t2_wdata", mem_w_data, 32'h1234_BEEF);
        do_ls(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h24);
        chk("t2_lw", ls_rdata, 32'h1234_BEEF);
        // alignment and range errors
        do_ls(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 32'h11);
        do_ls(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 32'h3FC);
        do_ls(1'b1, 2'd2, 1'b0, 32'h11, 32'h5555_5555, 32'h400);
        do_ls(1'b1, 2'd3, 1'b0, 32'h10, 32'h5555_5555, 32'h10);
        do_ls(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 32'h3FC);
        for (int i = 32'h3FD; i <= 32'h400; i++) do_ls(1'b0, 2'd2, 1'b0, 32'(i), 32'h0, 32'h3FD);
        do_ls(1'b0, 2'd0, 1'b0, 32'h3FF, 32'h0, 32'h3FF);
        do_ls(1'b1, 2'd0, 1'b0, 32'h400, 32'hAB, 32'h404);
        // fetch hazard on the stored word, none on another word
        do_ls(1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFE_F00D, 32'h10);
        chk("t4_fetch_new", if_rdata, 32'hCAFE_F00D);
        do_ls(1'b1, 2'd0, 1'b0, 32'h11, 32'h55, 32'h20);
        // back-to-back store then load with ls_req held
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_unsigned = 1'b0; ls_addr = 32'h20; ls_wdata = 32'hAA;
        n = 0;
        do begin tick; n++; end while (!ls_done && n < 6);
        chk("t5_st_lat", n, 32'd2);
        m_store(2'd0, 32'h20, 32'hAA);
        ls_we = 1'b0; ls_unsigned = 1'b1;
        n = 0;
        do begin tick; n++; end while (!ls_done && n < 6);
        chk("t5_ld_lat", n, 32'd2);
        chk("t5_lbu", ls_rdata, 32'h0000_00AA);
        ls_req = 1'b0;
        tick;
        // random traffic
        for (int k = 0; k < 300; k++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = ($urandom_range(0, 7) == 0) ? 32'h3F0 + $urandom_range(0, 31) : $urandom_range(0, 63);
            fa = ($urandom_range(0, 2) == 0) ? (a / 4) * 4 : $urandom_range(0, 67);
            if_req = ($urandom_range(0, 3) != 0);
            do_ls(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, fa);
        end
        if_req = 1'b1;
        // reset during ST_WRITE; data equals current word so landing or not is harmless
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h30; ls_wdata = ref_word(32'h30);
        tick;
        chk("t6_wen", 32'(mem_w_enable), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_wen_async", 32'(mem_w_enable), 32'd0);
        chk("t6_done", 32'(ls_done), 32'd0);
        chk("t6_rdata", ls_rdata, 32'd0);
        ls_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick;
        chk("t6_done_post", 32'(ls_done), 32'd0);
        chk("t6_rdata_post", ls_rdata, 32'd0);
        do_ls(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'h30);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
